// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 32-bit pipelined CPU. Owns the program
// counter, issues word requests to instruction memory over a ready handshake
// and loads the IF/ID pipeline register read by the decode stage.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   imem_req        : fetch request valid (registered, 1 every cycle after reset)
//   imem_addr       : word-aligned fetch address (slice of the PC register)
//   imem_rdata      : instruction word, valid while imem_ready=1
//   imem_ready      : the outstanding request completes this cycle
//   stall           : hazard unit holds PC and IF/ID
//   redirect        : taken branch/jump, discard the sequential path
//   redirect_pc     : redirect target (bits [1:0] forced to zero)
//   pc              : current fetch PC
//   if_id_valid     : IF/ID holds a real instruction
//   if_id_instr     : latched instruction, NOP_INSTR for a bubble
//   if_id_pc4       : address of the latched instruction + 4 (0 for a bubble)
//   if_id_rs/rt/rd  : register-address fields of if_id_instr
//   if_id_imm       : 16-bit immediate field of if_id_instr
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic [4:0]  if_id_rs,
   output logic [4:0]  if_id_rt,
   output logic [4:0]  if_id_rd,
   output logic [15:0] if_id_imm
);

   typedef enum logic {
      S_FETCH = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        req_q, req_d;
   logic        valid_q, valid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;

   logic [31:0] redirect_aligned;
   logic [31:0] pc_plus4;

   // Masking (rather than slicing) keeps every redirect_pc bit in use.
   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
   // 32-bit wrap-around is intended: 0xFFFF_FFFC + 4 = 0.
   assign pc_plus4         = pc_q + 32'd4;

   // -------------------------------------------------------------------------
   // Next-state / datapath logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      req_d   = 1'b1;
      valid_d = valid_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;

      unique case (state_q)
         S_FETCH: begin
            if (!req_q) begin
               // First cycle after reset: nothing is outstanding, so a ready
               // strobe carries no data. A redirect can be taken directly.
               if (redirect) begin
                  pc_d = redirect_aligned;
               end
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc4_d   = 32'd0;
            end else if (redirect && imem_ready) begin
               // Response belongs to the wrong path; drop it.
               pc_d    = redirect_aligned;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc4_d   = 32'd0;
            end else if (redirect) begin
               // The request at pc_q is still in flight and its address must
               // stay stable, so park the target until it completes.
               tgt_d   = redirect_aligned;
               state_d = S_DRAIN;
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc4_d   = 32'd0;
            end else if (stall) begin
               // Hold PC and IF/ID; a completed word is dropped and the same
               // address is simply requested again.
            end else if (imem_ready) begin
               valid_d = 1'b1;
               instr_d = imem_rdata;
               pc4_d   = pc_plus4;
               pc_d    = pc_plus4;
            end else begin
               // Memory wait state.
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
               pc4_d   = 32'd0;
            end
         end

         S_DRAIN: begin
            // IF/ID keeps the bubble; stall has no effect while draining.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc4_d   = 32'd0;
            if (redirect) begin
               tgt_d = redirect_aligned;
            end
            if (imem_ready) begin
               // The newest target wins, including one arriving this cycle.
               pc_d    = redirect ? redirect_aligned : tgt_q;
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         tgt_q   <= 32'd0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         instr_q <= NOP_INSTR;
         pc4_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tgt_q   <= tgt_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The PC never moves while a request is outstanding (wait or DRAIN), so it
   // is also the stable outstanding address.
   assign imem_addr   = pc_q;
   assign imem_req    = req_q;
   assign pc          = pc_q;
   assign if_id_valid = valid_q;
   assign if_id_instr = instr_q;
   assign if_id_pc4   = pc4_q;
   assign if_id_rs    = instr_q[25:21];
   assign if_id_rt    = instr_q[20:16];
   assign if_id_rd    = instr_q[15:11];
   assign if_id_imm   = instr_q[15:0];

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage: directed self-checking bench for fetch_stage. Memory returns
// address ^ 32'hA5A5_0000. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [4:0]  if_id_rs;
   logic [4:0]  if_id_rt;
   logic [4:0]  if_id_rd;
   logic [15:0] if_id_imm;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

   fetch_stage dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .pc         (pc),
      .if_id_valid(if_id_valid),
      .if_id_instr(if_id_instr),
      .if_id_pc4  (if_id_pc4),
      .if_id_rs   (if_id_rs),
      .if_id_rt   (if_id_rt),
      .if_id_rd   (if_id_rd),
      .if_id_imm  (if_id_imm)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streaming-word check: fetched instruction from address a, IF/ID pc4 = a+4.
   task automatic test_stream_word(input string tag, input logic [31:0] a);
      logic [31:0] e;
      e = a ^ 32'hA5A5_0000;
      tests_run++;
      if (if_id_valid !== 1'b1 || if_id_instr !== e || if_id_pc4 !== a + 32'd4 ||
          pc !== a + 32'd4 || if_id_rs !== e[25:21] || if_id_rt !== e[20:16] ||
          if_id_rd !== e[15:11] || if_id_imm !== e[15:0]) begin
         tests_failed++;
         $display("FAIL %s addr=%h: got valid=%b instr=%h pc4=%h pc=%h rs=%0d rt=%0d rd=%0d imm=%h, want valid=1 instr=%h pc4=%h pc=%h",
                  tag, a, if_id_valid, if_id_instr, if_id_pc4, pc, if_id_rs, if_id_rt,
                  if_id_rd, if_id_imm, e, a + 32'd4, a + 32'd4);
      end else begin
         $display("[TB] %s addr=%h instr=%h pc4=%h ok", tag, a, if_id_instr, if_id_pc4);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; imem_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      tick(); tick();
      tests_run++;
      if (pc !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || if_id_valid !== 1'b0 ||
          if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0 || if_id_rs !== 5'd0 ||
          if_id_rt !== 5'd0 || if_id_rd !== 5'd0 || if_id_imm !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_values: got pc=%h req=%b addr=%h valid=%b instr=%h pc4=%h, want all 0",
                  pc, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4);
      end else $display("[TB] reset_values ok");
      rst = 1'b0;
      tick();
      tests_run++;
      if (imem_req !== 1'b1 || pc !== 32'd0 || imem_addr !== 32'd0 || if_id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got req=%b pc=%h addr=%h valid=%b, want req=1 pc=0 addr=0 valid=0",
                  imem_req, pc, imem_addr, if_id_valid);
      end else $display("[TB] reset_release ok");
   endtask

   task automatic test_stream();
      // Hand-checked first word: 0xA5A50000 -> rs=13, rt=5, rd=0, imm=0.
      tick();
      tests_run++;
      if (if_id_instr !== 32'hA5A5_0000 || if_id_rs !== 5'd13 || if_id_rt !== 5'd5 ||
          if_id_rd !== 5'd0 || if_id_imm !== 16'h0000 || if_id_pc4 !== 32'd4) begin
         tests_failed++;
         $display("FAIL first_word: got instr=%h rs=%0d rt=%0d rd=%0d imm=%h pc4=%h, want instr=a5a50000 rs=13 rt=5 rd=0 imm=0000 pc4=4",
                  if_id_instr, if_id_rs, if_id_rt, if_id_rd, if_id_imm, if_id_pc4);
      end else $display("[TB] first_word ok");
      for (logic [31:0] a = 32'h4; a < 32'h10; a += 4) begin
         tick();
         test_stream_word("stream", a);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (pc !== 32'h10 || if_id_valid !== 1'b1 || if_id_instr !== (32'hC ^ 32'hA5A5_0000) ||
             if_id_pc4 !== 32'h10 || imem_addr !== 32'h10) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: got pc=%h valid=%b instr=%h pc4=%h addr=%h, want pc=10 valid=1 instr=a5a5000c pc4=10 addr=10",
                     i, pc, if_id_valid, if_id_instr, if_id_pc4, imem_addr);
         end else $display("[TB] stall_hold[%0d] ok", i);
      end
      stall = 1'b0;
      for (logic [31:0] a = 32'h10; a < 32'h20; a += 4) begin
         tick();
         test_stream_word("after_stall", a);
      end
   endtask

   task automatic test_wait_state();
      imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0 ||
             imem_addr !== 32'h20 || pc !== 32'h20 || imem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL wait_bubble[%0d]: got valid=%b instr=%h pc4=%h addr=%h pc=%h req=%b, want 0/0/0/20/20/1",
                     i, if_id_valid, if_id_instr, if_id_pc4, imem_addr, pc, imem_req);
         end else $display("[TB] wait_bubble[%0d] ok", i);
      end
      imem_ready = 1'b1;
      for (logic [31:0] a = 32'h20; a < 32'h40; a += 4) begin
         tick();
         test_stream_word("after_wait", a);
      end
   endtask

   task automatic test_redirect_drain();
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
      tick();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (imem_addr !== 32'h40 || pc !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0) begin
            tests_failed++;
            $display("FAIL drain_hold[%0d]: got addr=%h pc=%h valid=%b instr=%h, want addr=40 pc=40 valid=0 instr=0",
                     i, imem_addr, pc, if_id_valid, if_id_instr);
         end else $display("[TB] drain_hold[%0d] ok", i);
         if (i == 0) tick();
      end
      imem_ready = 1'b1;
      tick();
      tests_run++;
      if (pc !== 32'h100 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || imem_addr !== 32'h100) begin
         tests_failed++;
         $display("FAIL drain_exit: got pc=%h valid=%b instr=%h addr=%h, want pc=100 valid=0 instr=0 addr=100",
                  pc, if_id_valid, if_id_instr, imem_addr);
      end else $display("[TB] drain_exit ok");
      tick();
      test_stream_word("post_redirect", 32'h100);
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      tick();
      stall = 1'b0; redirect = 1'b0;
      tests_run++;
      if (pc !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0) begin
         tests_failed++;
         $display("FAIL redirect_over_stall: got pc=%h valid=%b instr=%h pc4=%h, want pc=200 bubble",
                  pc, if_id_valid, if_id_instr, if_id_pc4);
      end else $display("[TB] redirect_over_stall ok");
      tick();
      test_stream_word("post_redirect_stall", 32'h200);
   endtask

   task automatic test_back_to_back();
      // Two redirects while draining: the newer target must win.
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h400;
      tick();
      redirect_pc = 32'h501;
      tick();
      redirect = 1'b0; imem_ready = 1'b1;
      tick();
      tests_run++;
      if (pc !== 32'h500 || if_id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL newest_target: got pc=%h valid=%b, want pc=500 valid=0", pc, if_id_valid);
      end else $display("[TB] newest_target ok");
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 1'b0;
      tests_run++;
      if (pc !== 32'hFFFF_FFFC || if_id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL wrap_target: got pc=%h valid=%b, want pc=fffffffc valid=0", pc, if_id_valid);
      end else $display("[TB] wrap_target ok");
      tick();
      tests_run++;
      if (if_id_instr !== 32'h5A5A_FFFC || if_id_pc4 !== 32'h0 || pc !== 32'h0 || if_id_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL wrap_word0: got instr=%h pc4=%h pc=%h valid=%b, want instr=5a5afffc pc4=0 pc=0 valid=1",
                  if_id_instr, if_id_pc4, pc, if_id_valid);
      end else $display("[TB] wrap_word0 ok");
      tick();
      tests_run++;
      if (if_id_instr !== 32'hA5A5_0000 || if_id_pc4 !== 32'h4 || pc !== 32'h4) begin
         tests_failed++;
         $display("FAIL wrap_word1: got instr=%h pc4=%h pc=%h, want instr=a5a50000 pc4=4 pc=4",
                  if_id_instr, if_id_pc4, pc);
      end else $display("[TB] wrap_word1 ok");
   endtask

   task automatic test_reset_in_drain();
      imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h300;
      tick();
      redirect = 1'b0;
      tests_run++;
      if (imem_addr !== 32'h4 || pc !== 32'h4 || if_id_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL enter_drain: got addr=%h pc=%h valid=%b, want addr=4 pc=4 valid=0",
                  imem_addr, pc, if_id_valid);
      end else $display("[TB] enter_drain ok");
      rst = 1'b1; imem_ready = 1'b1;
      tick();
      tests_run++;
      if (pc !== 32'd0 || imem_req !== 1'b0 || imem_addr !== 32'd0 || if_id_valid !== 1'b0 ||
          if_id_instr !== 32'd0 || if_id_pc4 !== 32'd0 || if_id_imm !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_in_drain: got pc=%h req=%b addr=%h valid=%b instr=%h pc4=%h, want all 0",
                  pc, imem_req, imem_addr, if_id_valid, if_id_instr, if_id_pc4);
      end else $display("[TB] reset_in_drain ok");
      rst = 1'b0;
      tick();
      tick();
      // Back in FETCH with the parked target forgotten: fetch starts at 0.
      test_stream_word("post_reset", 32'h0);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_wait_state();
      test_redirect_drain();
      test_redirect_stall();
      test_back_to_back();
      test_wrap();
      test_reset_in_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 32-bit pipelined CPU. It owns the program counter, issues word requests to instruction memory over a ready handshake, and loads the IF/ID pipeline register. The decode stage reads that register: the register-address decoder takes `if_id_rs`/`if_id_rt`/`if_id_rd`, and the 16-to-32 sign extender takes `if_id_imm`. The block supports hazard stalls, branch/jump redirects and memory wait states.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0000: instruction word inserted as a bubble.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch byte address, word aligned.
- `imem_rdata` in 32: instruction word; valid when `imem_ready`=1.
- `imem_ready` in 1: request completes this cycle.
- `stall` in 1: hazard unit requests that PC and IF/ID hold.
- `redirect` in 1: taken branch/jump; discard the sequential path.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `pc` out 32: current fetch PC.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_instr` out 32: latched instruction, or `NOP_INSTR` for a bubble.
- `if_id_pc4` out 32: address of the latched instruction + 4.
- `if_id_rs`, `if_id_rt`, `if_id_rd` out 5 each: `if_id_instr[25:21]`, `[20:16]`, `[15:11]`.
- `if_id_imm` out 16: `if_id_instr[15:0]`.

## Operation
- States:
  - FETCH: normal operation.
  - DRAIN: a redirect arrived while a request was outstanding and not yet acknowledged.
  - A target register `tgt` (32 bits) stores the pending redirect address.
- Handshake rules:
  - `imem_addr` = `pc` in FETCH. In DRAIN it holds the outstanding address.
  - While `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change.
  - `imem_req`=1 in every cycle after reset is released.
- FETCH, in priority order:
  - `redirect` and `imem_ready`: discard `imem_rdata`; `pc`<=`{redirect_pc[31:2],2'b00}`; IF/ID <= bubble. Stay in FETCH.
  - `redirect` and not `imem_ready`: `tgt`<=aligned `redirect_pc`; IF/ID <= bubble; `pc` holds. Go to DRAIN.
  - `stall`: `pc` and IF/ID hold. If `imem_ready`=1 the data is discarded and the same address is re-requested next cycle.
  - `imem_ready`: IF/ID <= {valid=1, `imem_rdata`, `pc`+4}; `pc`<=`pc`+4.
  - Otherwise (wait state): IF/ID <= bubble; `pc` holds.
- DRAIN:
  - IF/ID holds the bubble. `stall` is ignored.
  - A new `redirect` overwrites `tgt`; the newest target wins.
  - On `imem_ready`: discard data; `pc`<=`tgt`, or the aligned `redirect_pc` if `redirect` is asserted this cycle. Go to FETCH.
- Bubble definition: `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0.
- Arithmetic: PC+4 is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
- `redirect` has priority over `stall`, because the stalled instruction is on the wrong path.

## Timing
- Reset values while `rst`=1:
  - `pc`=`RESET_PC`; state FETCH; `tgt`=0.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - IF/ID = bubble (`if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc4`=0, field outputs from `NOP_INSTR`).
- `rst` asserted mid-request or in DRAIN: all state returns to reset values on the next edge. Any in-flight response is ignored.
- Latency:
  - A word accepted at edge N appears on `if_id_*` after edge N.
  - With zero-wait memory (`imem_ready` tied 1), throughput is 1 instruction per cycle.
  - First fetch from `RESET_PC` is issued in the first cycle after `rst` falls.
- Redirect penalty: 1 bubble if the redirect coincides with `imem_ready`. Otherwise 1 bubble plus the remaining wait cycles of the outstanding request.
- All outputs are registered, except `imem_addr`, `if_id_rs`/`rt`/`rd` and `if_id_imm`, which are wire slices of registers.

## Test plan
- Reset then `imem_ready`=1, memory returns word = address ^ 32'hA5A5_0000 → `if_id_instr` sequence 0xA5A50000, 0xA5A50004, … one per cycle; `if_id_pc4`=4, 8, …; `if_id_rs`/`rt`/`rd`/`imm` match the instruction slices.
- `stall` high for 3 cycles during streaming at PC=0x10 → `pc` and IF/ID frozen for 3 cycles; the next accepted word comes from 0x10; no instruction is skipped or duplicated.
- 2-cycle wait state at PC=0x20 (`imem_ready` low for 2 cycles) → 2 bubbles with `if_id_valid`=0; `imem_addr` stays 0x20 throughout.
- `redirect`=1, `redirect_pc`=0x103 while `imem_ready`=0 at PC=0x40; `imem_ready` returns 2 cycles later → DRAIN for 2 cycles; `imem_addr` holds 0x40; the 0x40 data is discarded; the next fetch is from 0x100.
- `redirect` and `stall` together with `imem_ready`=1 → redirect wins; `pc`=target; IF/ID = bubble.
- `redirect_pc`=0xFFFF_FFFC, then stream 2 words → `if_id_pc4`=0x0000_0000 and then 0x0000_0004 (wrap). Separately, assert `rst` in DRAIN → all outputs at their reset values after the next edge.
